// File: rtl/pipe_stage_reg_if.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg_if
//
// One valid/ready channel of the pipeline: an instruction is a control
// bundle plus a data bundle, transferred on a cycle where valid & ready.
//
// Signals:
//   valid  producer presents an instruction
//   ready  consumer can take it this cycle
//   ctrl   control bundle (CTRL_W bits)
//   data   data bundle    (DATA_W bits)
//
// Modports:
//   master  producer side (drives valid/ctrl/data, samples ready)
//   slave   consumer side (samples valid/ctrl/data, drives ready)
// ---------------------------------------------------------------------------
interface pipe_stage_reg_if #(
    parameter int CTRL_W = 4,
    parameter int DATA_W = 101
);
    logic              valid;
    logic              ready;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;

    modport master (
        output valid,
        output ctrl,
        output data,
        input  ready
    );

    modport slave (
        input  valid,
        input  ctrl,
        input  data,
        output ready
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
//
// Parametrised inter-stage pipeline register for the MIPS datapath. Holds up
// to two instructions (main + skid entry) behind a valid/ready handshake so
// a downstream stall never drops or duplicates an instruction, and in_ready
// never depends combinationally on out_ready.
//
// Ports:
//   clk          clock, rising edge
//   reset        asynchronous, active-low reset
//   flush        synchronous flush, empties the stage (beats accept/emit)
//   in_bus       upstream channel (slave):  in_valid/in_ready/in_ctrl/in_data
//   out_bus      downstream channel (master): out_valid/out_ready/out_ctrl/out_data
//   occupancy    number of held entries (0, 1, 2)
//   stat_clr     synchronous clear of stall_count (beats increment)
//   stall_count  saturating count of cycles with out_valid & !out_ready
// ---------------------------------------------------------------------------
module pipe_stage_reg #(
    parameter int CTRL_W      = 4,
    parameter int DATA_W      = 101,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    pipe_stage_reg_if.slave        in_bus,
    pipe_stage_reg_if.master       out_bus,
    output logic [1:0]             occupancy,
    input  logic                   stat_clr,
    output logic [STALL_CNT_W-1:0] stall_count
);

    // Encoding equals the number of held entries, so occupancy is the state.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [CTRL_W-1:0]      main_ctrl_q, skid_ctrl_q;
    logic [DATA_W-1:0]      main_data_q, skid_data_q;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic accept, emit;
    logic load_main_in, load_main_skid, load_skid;
    logic in_ready, out_valid;

    function automatic logic [STALL_CNT_W-1:0] sat_inc(
        input logic [STALL_CNT_W-1:0] v
    );
        return (&v) ? v : v + 1'b1;
    endfunction

    // Handshake decode: ready/valid come from state only.
    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign accept    = in_bus.valid & in_ready;
    assign emit      = out_valid & out_bus.ready;

    assign in_bus.ready  = in_ready;
    assign out_bus.valid = out_valid;
    assign out_bus.data  = main_data_q;
    // Control bits of a bubble must be inert even though data is stale.
    assign out_bus.ctrl  = main_ctrl_q & {CTRL_W{out_valid}};
    assign occupancy     = state_q;
    assign stall_count   = stall_cnt_q;

    // Next-state and register load selection.
    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d      = ONE;
                        load_main_in = 1'b1;
                    end
                end
                ONE: begin
                    if (accept && !emit) begin
                        state_d   = FULL;
                        load_skid = 1'b1;
                    end else if (emit && !accept) begin
                        state_d = EMPTY;
                    end else if (accept && emit) begin
                        load_main_in = 1'b1;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only an emit can happen.
                    if (emit) begin
                        state_d        = ONE;
                        load_main_skid = 1'b1;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stat_clr) begin
            stall_cnt_d = '0;
        end else if (out_valid && !out_bus.ready) begin
            stall_cnt_d = sat_inc(stall_cnt_q);
        end
    end

    // State and statistics registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= EMPTY;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Control bundle registers: flush clears them so no stale control
    // can resurface; data registers are left alone on flush.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            main_ctrl_q <= '0;
            skid_ctrl_q <= '0;
        end else if (flush) begin
            main_ctrl_q <= '0;
            skid_ctrl_q <= '0;
        end else begin
            if (load_main_in) begin
                main_ctrl_q <= in_bus.ctrl;
            end else if (load_main_skid) begin
                main_ctrl_q <= skid_ctrl_q;
            end
            if (load_skid) begin
                skid_ctrl_q <= in_bus.ctrl;
            end
        end
    end

    // Data bundle registers: written only on the listed transitions.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            main_data_q <= '0;
            skid_data_q <= '0;
        end else begin
            if (load_main_in) begin
                main_data_q <= in_bus.data;
            end else if (load_main_skid) begin
                main_data_q <= skid_data_q;
            end
            if (load_skid) begin
                skid_data_q <= in_bus.data;
            end
        end
    end

endmodule
